// File: rtl/sprite_addr_cal.sv
// Per-sprite texel address generator: window hit test plus pattern-memory address, one-cycle latency.
// Optional vertical flip on sprite_info[9] when SPRITE_ADDR_VFLIP_EN is defined.
module sprite_addr_cal #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned COORD_W = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [79:0]          pattern_info,
    input  logic [31:0]          sprite_info,
    input  logic [COORD_W-1:0]   hcount,
    input  logic [COORD_W-1:0]   vcount,
    output logic [ADDR_W-1:0]    addr_output,
    output logic                 valid
);

    localparam int unsigned FIELD_W = 16;
    localparam int unsigned ATTR_W  = 10;
    localparam int unsigned DW      = COORD_W + 1;
    localparam int unsigned EW      = FIELD_W + 1;

    typedef struct packed {
        logic [FIELD_W-1:0] append;
        logic [FIELD_W-1:0] res_h;
        logic [FIELD_W-1:0] res_v;
        logic [FIELD_W-1:0] act_h;
        logic [FIELD_W-1:0] act_v;
    } pattern_t;

    typedef struct packed {
        logic               visible;
        logic               hflip;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [ATTR_W-1:0]  attr;
    } sprite_t;

    pattern_t           pat;
    sprite_t            spr;
    logic [DW-1:0]      dx;
    logic [DW-1:0]      dy;
    logic               h_in;
    logic               v_in;
    logic               inside_c;
    logic [ADDR_W-1:0]  col_c;
    logic [ADDR_W-1:0]  row_c;
    logic [ADDR_W-1:0]  addr_c;

    assign pat = pattern_t'(pattern_info);
    assign spr = sprite_t'(sprite_info);

`ifdef SPRITE_ADDR_VFLIP_EN
    logic [ATTR_W-2:0] attr_unused;
    assign attr_unused = spr.attr[ATTR_W-2:0];
`else
    logic [ATTR_W-1:0] attr_unused;
    assign attr_unused = spr.attr;
`endif

    // Window test in widened arithmetic so x+act_h and y+act_v cannot wrap.
    always_comb begin
        dx       = DW'(hcount) - DW'(spr.x);
        dy       = DW'(vcount) - DW'(spr.y);
        h_in     = (hcount >= spr.x) && (EW'(dx) < EW'(pat.act_h)) && (EW'(dx) < EW'(pat.res_h));
        v_in     = (vcount >= spr.y) && (EW'(dy) < EW'(pat.act_v)) && (EW'(dy) < EW'(pat.res_v));
        inside_c = spr.visible && h_in && v_in;
    end

    // Texel column/row selection and address, wrapping modulo 2^ADDR_W.
    always_comb begin
        col_c = ADDR_W'(dx);
        if (spr.hflip) begin
            col_c = ADDR_W'(pat.act_h) - ADDR_W'(1) - ADDR_W'(dx);
        end
        row_c = ADDR_W'(dy);
`ifdef SPRITE_ADDR_VFLIP_EN
        if (spr.attr[ATTR_W-1]) begin
            row_c = ADDR_W'(pat.act_v) - ADDR_W'(1) - ADDR_W'(dy);
        end
`endif
        addr_c = ADDR_W'(pat.append) + ADDR_W'(row_c * ADDR_W'(pat.res_h)) + col_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid       <= 1'b0;
            addr_output <= '0;
        end else begin
            valid       <= inside_c;
            addr_output <= inside_c ? addr_c : '0;
        end
    end

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed bench for sprite_addr_cal with hand-computed texel addresses.
module tb_sprite_addr_cal;

    logic        clk;
    logic        reset_n;
    logic [79:0] pattern_info;
    logic [31:0] sprite_info;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] addr_output;
    logic        valid;

    int n_tests;
    int n_fail;

    sprite_addr_cal #(.ADDR_W(16), .COORD_W(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pattern_info (pattern_info),
        .sprite_info  (sprite_info),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] mk_pat(input logic [15:0] append, input logic [15:0] res_h,
                                           input logic [15:0] res_v, input logic [15:0] act_h,
                                           input logic [15:0] act_v);
        return {append, res_h, res_v, act_h, act_v};
    endfunction

    function automatic logic [31:0] mk_spr(input logic vis, input logic hflip,
                                           input logic [9:0] x, input logic [9:0] y,
                                           input logic [9:0] attr);
        return {vis, hflip, x, y, attr};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v);
        hcount = h;
        vcount = v;
        step();
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd64, 16'd64);
        sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        hcount       = 10'd100;
        vcount       = 10'd50;

        step();
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_addr", 32'(addr_output), 32'd0);

        reset_n = 1'b1;
        drive(10'd100, 10'd50);
        check("origin_valid", 32'(valid), 32'd1);
        check("origin_addr", 32'(addr_output), 32'd0);

        drive(10'd163, 10'd113);
        check("corner_valid", 32'(valid), 32'd1);
        check("corner_addr", 32'(addr_output), 32'd4095);

        drive(10'd164, 10'd113);
        check("right_edge_valid", 32'(valid), 32'd0);
        check("right_edge_addr", 32'(addr_output), 32'd0);

        drive(10'd163, 10'd114);
        check("bottom_edge_valid", 32'(valid), 32'd0);

        drive(10'd99, 10'd50);
        check("left_edge_valid", 32'(valid), 32'd0);

        sprite_info = mk_spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0);
        drive(10'd100, 10'd50);
        check("hflip_left_addr", 32'(addr_output), 32'd63);
        drive(10'd163, 10'd50);
        check("hflip_right_addr", 32'(addr_output), 32'd0);
        check("hflip_right_valid", 32'(valid), 32'd1);
        drive(10'd110, 10'd52);
        check("hflip_mid_addr", 32'(addr_output), 32'd181);

        pattern_info = mk_pat(16'd2048, 16'd32, 16'd32, 16'd16, 16'd16);
        sprite_info  = mk_spr(1'b1, 1'b0, 10'd10, 10'd20, 10'd0);
        drive(10'd15, 10'd22);
        check("stride_valid", 32'(valid), 32'd1);
        check("stride_addr", 32'(addr_output), 32'd2117);
        drive(10'd26, 10'd22);
        check("stride_out_valid", 32'(valid), 32'd0);

        pattern_info = mk_pat(16'd0, 16'd8, 16'd32, 16'd16, 16'd16);
        drive(10'd20, 10'd22);
        check("res_h_clip_valid", 32'(valid), 32'd0);
        drive(10'd17, 10'd22);
        check("res_h_inside_addr", 32'(addr_output), 32'd23);

        pattern_info = mk_pat(16'hFFF0, 16'd64, 16'd64, 16'd64, 16'd64);
        sprite_info  = mk_spr(1'b1, 1'b0, 10'd0, 10'd0, 10'd0);
        drive(10'd32, 10'd0);
        check("wrap_addr", 32'(addr_output), 32'd16);

        pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd64, 16'd64);
        sprite_info  = mk_spr(1'b0, 1'b0, 10'd100, 10'd50, 10'd0);
        drive(10'd110, 10'd60);
        check("hidden_valid", 32'(valid), 32'd0);
        check("hidden_addr", 32'(addr_output), 32'd0);

        pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd0, 16'd64);
        sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        drive(10'd100, 10'd50);
        check("zero_w_valid", 32'(valid), 32'd0);

        pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd64, 16'd64);
        sprite_info  = mk_spr(1'b1, 1'b0, 10'd1000, 10'd50, 10'd0);
        drive(10'd1023, 10'd50);
        check("overflow_valid", 32'(valid), 32'd1);
        check("overflow_addr", 32'(addr_output), 32'd23);

        #3 reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(valid), 32'd0);
        check("async_reset_addr", 32'(addr_output), 32'd0);
        #1 reset_n = 1'b1;
        step();
        check("post_reset_valid", 32'(valid), 32'd1);
        check("post_reset_addr", 32'(addr_output), 32'd23);

`ifdef SPRITE_ADDR_VFLIP_EN
        sprite_info = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'b10_0000_0000);
        drive(10'd100, 10'd50);
        check("vflip_addr", 32'(addr_output), 32'd4032);
`else
        sprite_info = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'b10_0000_0000);
        drive(10'd100, 10'd50);
        check("attr_ignored_addr", 32'(addr_output), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_addr_cal.md
Name: sprite_addr_cal

Overview:
Per-sprite pixel address generator for the VGA sprite display path. It compares the current raster position against a sprite's screen window. When the position is inside a visible sprite, it produces the on-chip pattern-memory address of the corresponding texel plus a valid flag. One instance sits behind each sprite state buffer; the display block muxes the outputs and looks up the palette.

Parameters:
ADDR_W, 16, width of addr_output and of pattern-memory address arithmetic
COORD_W, 10, width of hcount/vcount and sprite X/Y fields

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
pattern_info  input  80  {append[79:64], res_h[63:48], res_v[47:32], act_h[31:16], act_v[15:0]}
sprite_info  input  32  {visible[31], hflip[30], x[29:20], y[19:10], attr[9:0]}
hcount  input  10  current raster column
vcount  input  10  current raster row
addr_output  output  16  pattern-memory address of current texel
valid  output  1  high when the current raster pixel is covered by the sprite

Behaviour:
- Interface: one clock, `clk`. Reset `reset_n` is asynchronous and active-low; while low, addr_output=0 and valid=0.
- Field meanings:
  - append: base address of the pattern in memory.
  - res_h: stored row stride in texels.
  - res_v: stored row count.
  - act_h/act_v: drawn window width/height in pixels.
- Geometry:
  - dx = hcount - x and dy = vcount - y, computed unsigned in 11+ bits.
  - The window is hcount in [x, x+act_h) and vcount in [y, y+act_v). Compute x+act_h and y+act_v at ≥17 bits so there is no wraparound.
- inside = visible & (hcount >= x) & (dx < act_h) & (vcount >= y) & (dy < act_v) & (dx < res_h) & (dy < res_v). Texels beyond the stored image are clipped.
- Column select: col = hflip ? (act_h-1-dx) : dx.
- Address: addr = append + dy*res_h + col, truncated to 16 bits (wraps modulo 2^16).
- Registered outputs, latency exactly 1 clk:
  - On each posedge, valid <= inside.
  - On each posedge, addr_output <= inside ? addr : 0.
- Inputs are sampled every cycle; there is no handshake. Changing sprite_info or pattern_info takes effect on the next edge.
- act_h=0 or act_v=0 → valid never asserts.
- attr[9:0] is ignored, except when the optional feature is enabled.
- visible=0 → valid=0 and addr_output=0, regardless of position.
- Reset asserted mid-frame clears the outputs immediately. The first edge after release produces normal output for the inputs present at that edge.

Optional Feature:
- Macro: SPRITE_ADDR_VFLIP_EN.
- When defined: sprite_info[9] is a vertical-flip bit, with row = vflip ? (act_v-1-dy) : dy used in place of dy in the address.
- When undefined: sprite_info[9] is ignored and row = dy.

Test Plan:
- Reset / visibility: pattern {0,64,64,64,64}, sprite visible x=100 y=50, reset_n low → outputs 0. Release, then drive hcount=100, vcount=50 → next cycle valid=1, addr=0.
- Far corner and edges: same setup, hcount=163, vcount=113 → valid=1, addr=4095. Then hcount=164 → valid=0, addr=0. Then vcount=114 → valid=0.
- Horizontal flip: hflip=1, hcount=100, vcount=50 → addr=63. Then hcount=163 → addr=0.
- Stride / base: append=2048, res_h=32, act_h=16, act_v=16, x=10, y=20; hcount=15, vcount=22 → addr=2117, valid=1. Then hcount=26 → valid=0.
- Hidden / zero size: visible=0 at an in-window position → valid=0, addr=0. visible=1 with act_h=0 → valid=0.
- Overflow and reset: x=1000, act_h=64, hcount=1023 → valid=1, dx=23. Assert reset_n low asynchronously mid-cycle → valid drops before the next edge.
- Vertical flip (only with SPRITE_ADDR_VFLIP_EN): attr[9]=1, 64x64 pattern, dy=0, dx=0 → addr=4032.
